// File: rtl/mul32u_seq_pkg.sv
// Shared arithmetic constants for the sequential multiplier and its sibling divider.
package mul32u_seq_pkg;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/mul32u_seq_if.sv
// Start/busy/done handshake and operand/result bus of the iterative multiplier.
interface mul32u_seq_if #(parameter int WIDTH = 32);
  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;

  modport master (output start, mcand, mplier, input busy, done, prod);
  modport slave  (input start, mcand, mplier, output busy, done, prod);
endinterface

// File: rtl/mul32u_step.sv
// One shift-add step: conditionally add the multiplicand into the high half, then
// shift the whole accumulator right by one, keeping the add carry as the new MSB.
module mul32u_step
  import mul32u_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] mc_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, mc_i} : '0);
    acc_hi_o = sum[WIDTH:1];
    acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/mul32u_seq.sv
// Iterative unsigned WIDTHxWIDTH multiplier, one shift-add step per clock,
// fixed WIDTH-cycle occupancy and a one-cycle done pulse.
module mul32u_seq
  import mul32u_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  mul32u_seq_if.slave  bus
);
  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   step_hi, step_lo;

  mul32u_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .mc_i     (mc_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mc_d     = mc_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = bus.mplier;
          mc_d     = bus.mcand;
        end
      end
      default: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        // Last step: publish the product on the same edge so busy drops with done.
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = ST_IDLE;
          prod_d  = {step_hi, step_lo};
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mc_q     <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mc_q     <= mc_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;
  assign bus.prod = prod_q;
endmodule

// File: tb/tb_mul32u_seq.sv
// Randomized bench for mul32u_seq against a cycle-count/product model plus literal cases.
module tb_mul32u_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  mul32u_seq_if #(.WIDTH(32)) bus ();

  mul32u_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: an accepted op occupies 32 edges, then its full 64-bit product appears with done.
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (bus.start) begin
          m_pend <= {32'b0, bus.mcand} * {32'b0, bus.mplier};
          m_left <= 32;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_prod <= m_pend;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks += 3;
      if (bus.busy !== (m_left != 0)) begin
        errors++;
        $display("FAIL busy @%0t: got %b want %b", $time, bus.busy, (m_left != 0));
      end
      if (bus.done !== m_done) begin
        errors++;
        $display("FAIL done @%0t: got %b want %b", $time, bus.done, m_done);
      end
      if (bus.prod !== m_prod) begin
        errors++;
        $display("FAIL prod @%0t: got %h want %h", $time, bus.prod, m_prod);
      end
    end
  end

  task automatic check64(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                       input bit inject, input string nm);
    int n = 0;
    bus.start = 1'b1; bus.mcand = a; bus.mplier = b;
    @(negedge clk);
    bus.start = 1'b0; bus.mcand = $urandom; bus.mplier = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (inject && (k == 5 || k == 20)) begin
        bus.start = 1'b1; bus.mcand = $urandom; bus.mplier = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = k;
        break;
      end
    end
    bus.start = 1'b0;
    check64({nm, " latency"}, 64'(n), 64'd32);
    check64({nm, " prod"}, bus.prod, exp);
  endtask

  initial begin
    logic [31:0] a, b, dvd, dvs;
    bus.start = 1'b0; bus.mcand = '0; bus.mplier = '0;
    repeat (2) @(negedge clk);
    check64("reset busy", 64'(bus.busy), 64'd0);
    check64("reset done", 64'(bus.done), 64'd0);
    check64("reset prod", bus.prod, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    do_op(32'd7, 32'd4, 64'h0000_0000_0000_001C, 1'b0, "7x4");
    @(negedge clk);
    do_op(32'h8000_0007, 32'd4, 64'h0000_0002_0000_001C, 1'b0, "hi7x4");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, "maxsq");
    do_op(32'd0, 32'h1234_5678, 64'd0, 1'b0, "zero");
    do_op(32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, "one");
    do_op(32'd1000, 32'd1000, 64'd1000000, 1'b1, "ignored starts");

    // Reset in the middle of a run: no result, no done.
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 32'd9; bus.mplier = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check64("midrun rst busy", 64'(bus.busy), 64'd0);
    check64("midrun rst prod", bus.prod, 64'd0);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done === 1'b1) seen++;
      end
      check64("midrun rst no done", 64'(seen), 64'd0);
    end

    // Reset and start together: start is dropped.
    rst = 1'b1; bus.start = 1'b1; bus.mcand = 32'd3; bus.mplier = 32'd3;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check64("rst+start busy", 64'(bus.busy), 64'd0);
    @(negedge clk);

    do_op(32'd3, 32'd5, 64'd15, 1'b0, "b2b first");
    do_op(32'd6, 32'd7, 64'd42, 1'b0, "b2b second");

    for (int i = 0; i < 1000; i++) begin
      case (i % 4)
        0: begin a = $urandom; b = $urandom; end
        1: begin
          // Quotient/divisor pair as the divider would produce it.
          dvd = $urandom; dvs = $urandom_range(1, 65535);
          a = dvd / dvs; b = dvs;
        end
        2: begin a = (i % 8 == 2) ? 32'hFFFF_FFFF : $urandom; b = 32'hFFFF_FFFF - i; end
        default: begin a = $urandom_range(0, 3); b = $urandom; end
      endcase
      do_op(a, b, {32'b0, a} * {32'b0, b}, (i % 50 == 0), "random");
      if (i % 3 == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
